// File: rtl/dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_bridge
// Brief    : Runs one MEM-stage data-memory access as a single transaction on
//            a valid/ready data bus with a variable-latency response. Stalls
//            the pipeline until completion and reports bus errors and
//            response timeouts as one-cycle access faults.
//            Optional build macro DMEM_POSTED_WRITE_EN: stores retire on
//            request acceptance and their response is tracked in the
//            background (faults on posted writes are imprecise).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_bridge #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_we,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [29:0]        r_addr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_rdata;
    logic               r_fault;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_tmo;
    logic               w_issue_go;
    logic               w_pending;
    logic               w_posted;
    logic               w_wait_rsp;
    logic               w_wait_tmo;
    logic               w_pend_fault;
    logic               w_fault_set;
    logic               w_unused;

    // Byte offset within the word is resolved by the controller's shifters.
    assign w_unused   = ^req_addr[1:0];

    assign w_accept   = (r_state == S_ISSUE) & bus_req_ready;
    assign w_tmo      = (r_cnt == c_tmo_last);
    assign w_wait_rsp = (r_state == S_WAIT) & bus_rsp_valid;
    assign w_wait_tmo = (r_state == S_WAIT) & ~bus_rsp_valid & w_tmo;

`ifdef DMEM_POSTED_WRITE_EN
    logic r_pending_wr;
    logic w_pend_rsp;
    logic w_pend_tmo;

    assign w_pending    = r_pending_wr;
    assign w_posted     = r_we;
    assign w_pend_rsp   = r_pending_wr & bus_rsp_valid;
    assign w_pend_tmo   = r_pending_wr & ~bus_rsp_valid & w_tmo;
    assign w_pend_fault = (w_pend_rsp & bus_rsp_err) | w_pend_tmo;

    // Track a store that retired before its bus response came back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_wr <= 1'b0;
        end else if (w_accept & r_we) begin
            r_pending_wr <= 1'b1;
        end else if (w_pend_rsp | w_pend_tmo) begin
            r_pending_wr <= 1'b0;
        end
    end
`else
    assign w_pending    = 1'b0;
    assign w_posted     = 1'b0;
    assign w_pend_fault = 1'b0;
`endif

    // A new request may leave IDLE unless a posted write is still outstanding;
    // its response arriving this very cycle releases the request immediately.
    assign w_issue_go  = req & (~w_pending | bus_rsp_valid);
    assign w_fault_set = (w_wait_rsp & bus_rsp_err) | w_wait_tmo | w_pend_fault;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the state-derived handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        stall         = req & (r_state != S_DONE);
        bus_req_valid = (r_state == S_ISSUE);
        case (r_state)
            S_IDLE: begin
                if (w_issue_go) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus_req_ready) begin
                    w_state_nxt = w_posted ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rsp_valid || w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request so the bus sees fields that cannot change mid-handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if ((r_state == S_IDLE) && w_issue_go) begin
            r_addr  <= req_addr[31:2];
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Response-wait counter; restarts at acceptance and runs while a response is owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) || w_pending) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Read word: loaded from the bus on load responses, zeroed on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_wait_rsp) begin
            if (!r_we) begin
                r_rdata <= bus_rsp_rdata;
            end
        end else if (w_wait_tmo) begin
            r_rdata <= '0;
        end
    end

    // Fault pulse, registered so it is exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_set;
        end
    end

    assign rdata         = r_rdata;
    assign access_fault  = r_fault;
    assign bus_req_addr  = {r_addr, 2'b00};
    assign bus_req_we    = r_we;
    assign bus_req_wdata = r_wdata;
    assign bus_req_wstrb = r_wstrb;

    // Dropping req mid-transaction does not abort it; flag it as misuse.
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == S_ISSUE) || (r_state == S_WAIT)) |-> req);

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bus_bridge
// Brief    : Scoreboard bench for dmem_bus_bridge. Directed transactions push
//            expected bus requests and completions into queues; independent
//            monitors pop and compare when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_bridge;

`ifdef DMEM_POSTED_WRITE_EN
    localparam bit c_posted = 1'b1;
`else
    localparam bit c_posted = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata;
    logic        stall;
    logic        access_fault;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    dmem_bus_bridge #(
        .TIMEOUT (8),
        .CNT_W   (7)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rdata         (rdata),
        .stall         (stall),
        .access_fault  (access_fault),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_addr  (bus_req_addr),
        .bus_req_we    (bus_req_we),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
    } breq_t;

    typedef struct {
        logic [31:0] rdata;
        int          faults;
        int          stalls;
    } cmpl_t;

    typedef struct {
        int          t;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    breq_t bq[$];
    cmpl_t cq[$];
    rsp_t  rq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int stall_cnt = 0;
    int fault_cnt = 0;
    int hold_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: plays back scheduled responses at their cycle number.
    initial begin
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0;
        bus_rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rq.size() > 0 && rq[0].t == cyc) begin
                bus_rsp_valid = 1'b1;
                bus_rsp_rdata = rq[0].d;
                bus_rsp_err   = rq[0].e;
                void'(rq.pop_front());
            end else begin
                bus_rsp_valid = 1'b0;
                bus_rsp_rdata = '0;
                bus_rsp_err   = 1'b0;
            end
        end
    end

    // Bus request monitor: fields must match the expected request every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_cnt = 0;
        end else if (bus_req_valid) begin
            hold_cnt++;
            if (bq.size() == 0) begin
                check("unexpected_bus_req", {31'd0, bus_req_valid}, 32'd0);
            end else begin
                check("bus_req_addr",  bus_req_addr,  bq[0].addr);
                check("bus_req_we",    {31'd0, bus_req_we}, {31'd0, bq[0].we});
                check("bus_req_wdata", bus_req_wdata, bq[0].wdata);
                check("bus_req_wstrb", {28'd0, bus_req_wstrb}, {28'd0, bq[0].wstrb});
                if (bus_req_ready) begin
                    check("bus_req_hold", hold_cnt, bq[0].hold);
                    void'(bq.pop_front());
                    hold_cnt = 0;
                end
            end
        end
    end

    // Completion monitor: counts stall and fault cycles per access and checks at retirement.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
            fault_cnt = 0;
        end else begin
            if (access_fault) fault_cnt++;
            if (req && stall) begin
                stall_cnt++;
            end else if (req && !stall) begin
                if (cq.size() == 0) begin
                    check("unexpected_completion", {31'd0, req}, 32'd0);
                end else begin
                    check("rdata",        rdata,     cq[0].rdata);
                    check("fault_pulses", fault_cnt, cq[0].faults);
                    check("stall_cycles", stall_cnt, cq[0].stalls);
                    void'(cq.pop_front());
                end
                stall_cnt = 0;
                fault_cnt = 0;
            end
        end
    end

    // One access: queue expectations, present the request, run the handshake.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int rdy_dly, input int rsp_dly,
                       input logic [31:0] rsp_data, input logic rsp_err,
                       input logic [31:0] exp_rdata, input int exp_fault, input int exp_stall);
        int n;
        bq.push_back('{addr & 32'hFFFF_FFFC, we, wdata, wstrb, rdy_dly + 1});
        cq.push_back('{exp_rdata, exp_fault, exp_stall});
        req       = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        n = 0;
        while (!bus_req_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_req_valid) check("req_valid_wait", {31'd0, bus_req_valid}, 32'd1);
        repeat (rdy_dly) begin
            @(posedge clk); #1;
        end
        bus_req_ready = 1'b1;
        rq.push_back('{cyc + rsp_dly, rsp_data, rsp_err});
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        n = 0;
        while (stall && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (stall) check("completion_wait", {31'd0, stall}, 32'd0);
        @(negedge clk); #1;
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        req           = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        bus_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata",      rdata, 32'd0);
        check("rst_fault",      {31'd0, access_fault}, 32'd0);
        check("rst_bus_valid",  {31'd0, bus_req_valid}, 32'd0);
        check("rst_bus_addr",   bus_req_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_stall",     {31'd0, stall}, 32'd0);
        check("idle_bus_valid", {31'd0, bus_req_valid}, 32'd0);

        // Load, immediate accept, response two cycles later.
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_1003, 32'h0, 4'b0000, 0, 2, 32'hDEAD_BEEF, 1'b0,
            32'hDEAD_BEEF, 0, 4);

        // Store with delayed accept; rdata must not change.
        @(posedge clk); #1;
        txn(1'b1, 32'h0000_2000, 32'h0000_AB00, 4'b0010, 3, 1, 32'h5555_5555, 1'b0,
            32'hDEAD_BEEF, 0, c_posted ? 5 : 6);

        // Load answered with an error.
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_3008, 32'h0, 4'b0000, 1, 3, 32'h1234_5678, 1'b1,
            32'h1234_5678, 1, 6);

        // Load never answered in time; response turns up 3 cycles after the fault.
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_4000, 32'h0, 4'b0000, 0, 12, 32'hBAD0_BAD0, 1'b0,
            32'h0000_0000, 1, 10);
        repeat (5) @(posedge clk);

        // Following load proves the late response and fault left no trace.
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_5004, 32'h0, 4'b0000, 2, 1, 32'hCAFE_F00D, 1'b0,
            32'hCAFE_F00D, 0, 5);

        // Reset asserted while waiting for a response.
        @(posedge clk); #1;
        bq.push_back('{32'h0000_7000, 1'b0, 32'h0, 4'b0000, 1});
        req       = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_7000;
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata",     rdata, 32'd0);
        check("async_rst_bus_valid", {31'd0, bus_req_valid}, 32'd0);
        check("async_rst_fault",     {31'd0, access_fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(1'b0, 32'h0000_7000, 32'h0, 4'b0000, 0, 2, 32'h0BAD_F00D, 1'b0,
            32'h0BAD_F00D, 0, 4);

        // Store then load back-to-back, write response 5 cycles after acceptance.
        @(posedge clk); #1;
        txn(1'b1, 32'h0000_8000, 32'hA5A5_A5A5, 4'b1111, 0, 5, 32'h0, 1'b0,
            32'h0BAD_F00D, 0, c_posted ? 2 : 7);
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_9000, 32'h0, 4'b0000, 0, 2, 32'h1357_2468, 1'b0,
            32'h1357_2468, 0, c_posted ? 7 : 4);

        repeat (6) @(posedge clk);
        #1;
        check("pending_completions", cq.size(), 32'd0);
        check("pending_bus_reqs",    bq.size(), 32'd0);
        check("pending_responses",   rq.size(), 32'd0);
        check("stray_fault_pulses",  fault_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
